// File: rtl/pulse_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_array_pkg
// Description : Shared control-state encoding for the pulse_array multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pulse_state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_pe.sv
`default_nettype none
// ============================================================================
// Module      : pulse_pe
// Description : Systolic processing element; multiply-accumulate with
//               registered pass-through of a (right), b (down) and the tag.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_pe #(
    parameter int WIDTH_left = 4,
    parameter int WIDTH_up   = 4,
    parameter int WIDTH_out  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_left-1:0] a,
    input  logic [WIDTH_up-1:0]   b,
    input  logic                  in_valid,
    input  logic                  clear,
    output logic [WIDTH_left-1:0] a_out,
    output logic [WIDTH_up-1:0]   b_out,
    output logic                  valid_out,
    output logic [WIDTH_out-1:0]  acc
);

    localparam int c_PROD_W = WIDTH_left + WIDTH_up;

    logic [WIDTH_left-1:0] a_q;
    logic [WIDTH_up-1:0]   b_q;
    logic                  valid_q;
    logic [WIDTH_out-1:0]  acc_q, acc_d;
    logic [c_PROD_W-1:0]   w_prod;

    assign w_prod = c_PROD_W'(a) * c_PROD_W'(b);

    // Accumulation wraps modulo 2^WIDTH_out; clear wins over a coincident tag.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (in_valid) begin
            acc_d = acc_q + WIDTH_out'(w_prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            a_q     <= a;
            b_q     <= b;
            valid_q <= in_valid;
            acc_q   <= acc_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign valid_out = valid_q;
    assign acc       = acc_q;

endmodule
`default_nettype wire

// File: rtl/pulse_array.sv
`default_nettype none
// ============================================================================
// Module      : pulse_array
// Description : Output-stationary systolic multiplier C = A x B with internal
//               input skew, beat/drain counting and a ready flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_array
    import pulse_array_pkg::*;
#(
    parameter int WIDTH_left      = 4,
    parameter int WIDTH_up        = 4,
    parameter int WIDTH_out       = 8,
    parameter int Mritx_M         = 3,
    parameter int Mritx_N         = 4,
    parameter int Mritx_L         = 3,
    parameter int Mritx_LOG2_size = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   valid_left,
    input  logic                                   valid_up,
    input  logic [Mritx_M*WIDTH_left-1:0]          left,
    input  logic [Mritx_L*WIDTH_up-1:0]            up,
    output logic                                   ready,
    output logic [Mritx_M*Mritx_L*WIDTH_out-1:0]   product
);

    localparam int              c_CW         = Mritx_LOG2_size;
    localparam logic [c_CW-1:0] c_LAST_BEAT  = c_CW'(Mritx_N - 1);
    localparam logic [c_CW-1:0] c_LAST_DRAIN = c_CW'(Mritx_M + Mritx_L - 1);

    pulse_state_t    state_q, state_d;
    logic [c_CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [c_CW-1:0] drain_cnt_q, drain_cnt_d;
    logic            w_accept;
    logic            w_new_job;
    logic            w_clear;
    logic [c_CW-1:0] w_beat_base;

    logic [WIDTH_left-1:0] w_a_in   [Mritx_M][Mritx_L];
    logic [WIDTH_left-1:0] w_a_out  [Mritx_M][Mritx_L];
    logic [WIDTH_up-1:0]   w_b_in   [Mritx_M][Mritx_L];
    logic [WIDTH_up-1:0]   w_b_out  [Mritx_M][Mritx_L];
    logic                  w_v_in   [Mritx_M][Mritx_L];
    logic                  w_v_out  [Mritx_M][Mritx_L];
    logic [WIDTH_out-1:0]  w_acc    [Mritx_M][Mritx_L];

    // Beats are refused only while draining; idle/done accept the next job.
    assign w_new_job   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign w_accept    = valid_left && valid_up && (state_q != ST_DRAIN);
    assign w_beat_base = w_new_job ? '0 : beat_cnt_q;
    assign ready       = (state_q == ST_DONE);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        w_clear     = 1'b0;
        if (state_q == ST_DRAIN) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (drain_cnt_q == c_LAST_DRAIN) begin
                state_d = ST_DONE;
            end
        end else if (w_accept) begin
            w_clear     = w_new_job;
            beat_cnt_d  = w_beat_base + 1'b1;
            drain_cnt_d = '0;
            state_d     = (w_beat_base == c_LAST_BEAT) ? ST_DRAIN : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Row lane i passes through i+1 registers (capture stage plus i skew).
    for (genvar i = 0; i < Mritx_M; i++) begin : g_row
        logic [WIDTH_left-1:0] a_sr_q [0:i];
        logic                  v_sr_q [0:i];
        logic                  w_edge_unused;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    a_sr_q[k] <= '0;
                    v_sr_q[k] <= 1'b0;
                end
            end else begin
                a_sr_q[0] <= w_accept ? left[i*WIDTH_left +: WIDTH_left] : '0;
                v_sr_q[0] <= w_accept;
                for (int k = 1; k <= i; k++) begin
                    a_sr_q[k] <= a_sr_q[k-1];
                    v_sr_q[k] <= v_sr_q[k-1];
                end
            end
        end

        assign w_a_in[i][0] = a_sr_q[i];
        assign w_v_in[i][0] = v_sr_q[i];
        assign w_edge_unused = ^{w_a_out[i][Mritx_L-1], w_v_out[i][Mritx_L-1]};

        for (genvar j = 0; j < Mritx_L; j++) begin : g_col
            if (j > 0) begin : g_a_chain
                assign w_a_in[i][j] = w_a_out[i][j-1];
                assign w_v_in[i][j] = w_v_out[i][j-1];
            end
            if (i > 0) begin : g_b_chain
                assign w_b_in[i][j] = w_b_out[i-1][j];
            end

            pulse_pe #(
                .WIDTH_left (WIDTH_left),
                .WIDTH_up   (WIDTH_up),
                .WIDTH_out  (WIDTH_out)
            ) u_pe (
                .clk       (clk),
                .rst       (rst),
                .a         (w_a_in[i][j]),
                .b         (w_b_in[i][j]),
                .in_valid  (w_v_in[i][j]),
                .clear     (w_clear),
                .a_out     (w_a_out[i][j]),
                .b_out     (w_b_out[i][j]),
                .valid_out (w_v_out[i][j]),
                .acc       (w_acc[i][j])
            );

            assign product[(i*Mritx_L+j)*WIDTH_out +: WIDTH_out] = w_acc[i][j];
        end
    end

    // Column lane j passes through j+1 registers before entering row 0.
    for (genvar j = 0; j < Mritx_L; j++) begin : g_colskew
        logic [WIDTH_up-1:0] b_sr_q [0:j];
        logic                w_edge_unused;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) begin
                    b_sr_q[k] <= '0;
                end
            end else begin
                b_sr_q[0] <= w_accept ? up[j*WIDTH_up +: WIDTH_up] : '0;
                for (int k = 1; k <= j; k++) begin
                    b_sr_q[k] <= b_sr_q[k-1];
                end
            end
        end

        assign w_b_in[0][j]  = b_sr_q[j];
        assign w_edge_unused = ^w_b_out[Mritx_M-1][j];
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_array
// Description : Directed self-checking bench for pulse_array (3x4 * 4x3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_left = 1'b0;
    logic        valid_up = 1'b0;
    logic [11:0] left = '0;
    logic [11:0] up = '0;
    logic        ready;
    logic [71:0] product;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_edge = 0;
    int first_edge = 0;
    int lat;
    int save_edge;
    int cnt;

    logic [7:0] e_zero [9] = '{default: 8'd0};
    logic [7:0] e_ones [9] = '{default: 8'd4};
    logic [7:0] e_ovf  [9] = '{default: 8'd132};
    logic [7:0] e_ramp [9] = '{8'd4, 8'd8, 8'd12, 8'd8, 8'd16, 8'd24, 8'd12, 8'd24, 8'd36};

    pulse_array u_dut (
        .clk        (clk),
        .rst        (rst),
        .valid_left (valid_left),
        .valid_up   (valid_up),
        .left       (left),
        .up         (up),
        .ready      (ready),
        .product    (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_grid(input string tag, input logic [7:0] exp [9]);
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("%s_c%0d%0d", tag, n / 3, n % 3), 32'(product[n*8 +: 8]), 32'(exp[n]));
        end
    endtask

    function automatic logic [71:0] pack9(input logic [7:0] e [9]);
        logic [71:0] v;
        v = '0;
        for (int n = 0; n < 9; n++) v[n*8 +: 8] = e[n];
        return v;
    endfunction

    task automatic beat(input logic [11:0] l, input logic [11:0] u, input logic vl, input logic vu);
        left       = l;
        up         = u;
        valid_left = vl;
        valid_up   = vu;
        @(posedge clk);
        #1;
        if (vl && vu) last_edge = cyc;
        valid_left = 1'b0;
        valid_up   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input int budget, output int l);
        l = -1;
        for (int c = 0; c < budget; c++) begin
            if (ready) begin
                l = cyc - last_edge;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic four(input logic [11:0] l, input logic [11:0] u);
        repeat (4) beat(l, u, 1'b1, 1'b1);
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 0);
        chk_grid("rst", e_zero);

        // All ones, consecutive beats
        four(12'h111, 12'h111);
        chk("ones_busy", 32'(ready), 0);
        wait_ready(40, lat);
        chk("ones_lat", lat, 6);
        chk_grid("ones", e_ones);

        // Ramp started while ready, with a surplus beat during drain
        beat(12'h321, 12'h321, 1'b1, 1'b1);
        chk("ramp_drop", 32'(ready), 0);
        repeat (3) beat(12'h321, 12'h321, 1'b1, 1'b1);
        save_edge = last_edge;
        beat(12'hFFF, 12'hFFF, 1'b1, 1'b1);
        last_edge = save_edge;
        wait_ready(40, lat);
        chk("ramp_lat", lat, 6);
        chk_grid("ramp", e_ramp);
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ready && (product == pack9(e_ramp))) cnt++;
        end
        chk("ramp_hold", cnt, 20);

        // Back-to-back: all-ones job over a finished ramp result
        beat(12'h111, 12'h111, 1'b1, 1'b1);
        chk("b2b_drop", 32'(ready), 0);
        repeat (3) beat(12'h111, 12'h111, 1'b1, 1'b1);
        wait_ready(40, lat);
        chk("b2b_lat", lat, 6);
        chk_grid("b2b", e_ones);

        // Overflow wraps modulo 256
        four(12'hFFF, 12'hFFF);
        wait_ready(40, lat);
        chk("ovf_lat", lat, 6);
        chk_grid("ovf", e_ovf);

        // Gapped beats with single-valid cycles in between
        beat(12'hFFF, 12'hFFF, 1'b1, 1'b0);
        chk("gap_single_keeps_ready", 32'(ready), 1);
        beat(12'h321, 12'h321, 1'b1, 1'b1);
        first_edge = last_edge;
        chk("gap_drop", 32'(ready), 0);
        idle(2);
        beat(12'hFFF, 12'hFFF, 1'b1, 1'b0);
        beat(12'h321, 12'h321, 1'b1, 1'b1);
        beat(12'hFFF, 12'hFFF, 1'b0, 1'b1);
        idle(3);
        beat(12'h321, 12'h321, 1'b1, 1'b1);
        idle(1);
        beat(12'hFFF, 12'h000, 1'b1, 1'b0);
        beat(12'h321, 12'h321, 1'b1, 1'b1);
        wait_ready(60, lat);
        chk("gap_lat", lat, 6);
        chk("gap_total", last_edge + lat - first_edge, 18);
        chk_grid("gap", e_ramp);

        // Reset mid-job aborts; next job is clean
        beat(12'h111, 12'h111, 1'b1, 1'b1);
        beat(12'h111, 12'h111, 1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            if (ready) cnt++;
            @(posedge clk);
            #1;
        end
        chk("rstmid_noready", cnt, 0);
        chk_grid("rstmid", e_zero);
        four(12'h111, 12'h111);
        wait_ready(40, lat);
        chk("post_rst_lat", lat, 6);
        chk_grid("post_rst", e_ones);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
